// File: rtl/keypad_cursor_pkg.sv
// keypad_cursor_pkg
//   Shared definitions for the keypad cursor block:
//     state_e     - auto-repeat FSM states
//     DIR_*       - one-hot codes of the packed direction vector {right, left, down, up}
//     cell_index  - linear index of grid cell (x, y) for a grid of 'cols' columns
package keypad_cursor_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DELAY  = 2'd1,
        S_REPEAT = 2'd2
    } state_e;

    localparam logic [3:0] DIR_UP    = 4'b0001;
    localparam logic [3:0] DIR_DOWN  = 4'b0010;
    localparam logic [3:0] DIR_LEFT  = 4'b0100;
    localparam logic [3:0] DIR_RIGHT = 4'b1000;

    function automatic int unsigned cell_index(input int unsigned x,
                                               input int unsigned y,
                                               input int unsigned cols);
        return y * cols + x;
    endfunction

endpackage

// File: rtl/keypad_line_seek.sv
// keypad_line_seek
//   Finds the nearest enabled entry on a wrapped line, stepping away from
//   'start' in one direction and excluding 'start' itself.
//   Ports:
//     start [LW-1:0]   current position on the line
//     len   [LW:0]     active line length (entries at or above len are ignored)
//     dec              1 = search towards lower indices, 0 = towards higher
//     mask  [MAXN-1:0] enable bit per line entry
//     found            an enabled entry other than start exists
//     idx   [LW-1:0]   nearest such entry (valid when found)
module keypad_line_seek import keypad_cursor_pkg::*; #(
    parameter int MAXN = 6,
    parameter int LW   = $clog2(MAXN)
) (
    input  logic [LW-1:0]   start,
    input  logic [LW:0]     len,
    input  logic            dec,
    input  logic [MAXN-1:0] mask,
    output logic            found,
    output logic [LW-1:0]   idx
);

    int unsigned cand;

    // Walk distances from farthest to nearest so the nearest hit is the
    // one that sticks.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        cand  = 0;
        for (int unsigned k = MAXN - 1; k >= 1; k--) begin
            if (k < 32'(len)) begin
                cand = dec ? (32'(start) + 32'(len) - k) : (32'(start) + k);
                if (cand >= 32'(len)) begin
                    cand = cand - 32'(len);
                end
                if (mask[cand[LW-1:0]]) begin
                    found = 1'b1;
                    idx   = cand[LW-1:0];
                end
            end
        end
    end

endmodule

// File: rtl/keypad_cursor.sv
// keypad_cursor
//   Moves a cursor over a COLS x ROWS grid of selectable cells from four
//   direction buttons, with press-and-hold auto-repeat.
//   Ports:
//     clk, rst                      clock, synchronous active-high reset
//     dir_up/down/left/right        debounced level-held buttons
//     cell_en [COLS*ROWS-1:0]       bit y*COLS+x set = cell (x,y) selectable
//     pos_x, pos_y                  registered cursor position
//     val                           pos_y*COLS+pos_x
//     moved                         one-cycle pulse aligned with a new position
//     no_valid                      cell_en is all zero
module keypad_cursor import keypad_cursor_pkg::*; #(
    parameter int COLS      = 6,
    parameter int ROWS      = 4,
    parameter int REP_DELAY = 25_000_000,
    parameter int REP_RATE  = 5_000_000
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            dir_up,
    input  logic                            dir_down,
    input  logic                            dir_left,
    input  logic                            dir_right,
    input  logic [COLS*ROWS-1:0]            cell_en,
    output logic [$clog2(COLS)-1:0]         pos_x,
    output logic [$clog2(ROWS)-1:0]         pos_y,
    output logic [$clog2(COLS*ROWS)-1:0]    val,
    output logic                            moved,
    output logic                            no_valid
);

    localparam int XW   = $clog2(COLS);
    localparam int YW   = $clog2(ROWS);
    localparam int VW   = $clog2(COLS * ROWS);
    localparam int MAXN = (COLS > ROWS) ? COLS : ROWS;
    localparam int LW   = $clog2(MAXN);
    localparam int CMAX = (REP_DELAY > REP_RATE) ? REP_DELAY : REP_RATE;
    localparam int CW   = $clog2(CMAX);

    localparam logic [LW:0]   COLS_LEN  = (LW + 1)'(COLS);
    localparam logic [LW:0]   ROWS_LEN  = (LW + 1)'(ROWS);
    localparam logic [CW-1:0] DLY_LAST  = CW'(REP_DELAY - 1);
    localparam logic [CW-1:0] RATE_LAST = CW'(REP_RATE - 1);

    logic [3:0]    dir_vec;
    logic [3:0]    dir_q, dir_d;
    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [XW-1:0] pos_x_q, pos_x_d;
    logic [YW-1:0] pos_y_q, pos_y_d;
    logic          moved_q, moved_d;

    logic            one_hot, step, horiz, cur_en;
    logic [MAXN-1:0] row_mask, col_mask, seek_mask;
    logic [LW-1:0]   seek_start, seek_idx;
    logic [LW:0]     seek_len;
    logic            seek_found;
    logic [XW-1:0]   snap_x;
    logic [YW-1:0]   snap_y;

    assign dir_vec  = {dir_right, dir_left, dir_down, dir_up};
    assign one_hot  = (dir_vec != 4'b0000) && ((dir_vec & (dir_vec - 4'd1)) == 4'b0000);
    assign dir_d    = dir_vec;
    assign horiz    = (dir_vec == DIR_LEFT) || (dir_vec == DIR_RIGHT);
    assign no_valid = ~|cell_en;
    assign val      = VW'(cell_index(32'(pos_x_q), 32'(pos_y_q), COLS));
    assign cur_en   = cell_en[val];
    assign pos_x    = pos_x_q;
    assign pos_y    = pos_y_q;
    assign moved    = moved_q;

    // Enable bits of the current row and current column.
    always_comb begin
        row_mask = '0;
        col_mask = '0;
        for (int unsigned i = 0; i < COLS; i++) begin
            row_mask[LW'(i)] = cell_en[VW'(cell_index(i, 32'(pos_y_q), COLS))];
        end
        for (int unsigned j = 0; j < ROWS; j++) begin
            col_mask[LW'(j)] = cell_en[VW'(cell_index(32'(pos_x_q), j, COLS))];
        end
    end

    // Lowest-index enabled cell; scanning downward leaves the lowest one last.
    always_comb begin
        snap_x = '0;
        snap_y = '0;
        for (int unsigned yy = ROWS; yy > 0; yy--) begin
            for (int unsigned xx = COLS; xx > 0; xx--) begin
                if (cell_en[VW'(cell_index(xx - 1, yy - 1, COLS))]) begin
                    snap_x = XW'(xx - 1);
                    snap_y = YW'(yy - 1);
                end
            end
        end
    end

    always_comb begin
        seek_start = horiz ? LW'(pos_x_q) : LW'(pos_y_q);
        seek_len   = horiz ? COLS_LEN : ROWS_LEN;
        seek_mask  = horiz ? row_mask : col_mask;
    end

    keypad_line_seek #(
        .MAXN (MAXN)
    ) u_seek (
        .start (seek_start),
        .len   (seek_len),
        .dec   ((dir_vec == DIR_UP) || (dir_vec == DIR_LEFT)),
        .mask  (seek_mask),
        .found (seek_found),
        .idx   (seek_idx)
    );

    // Auto-repeat FSM: 'step' requests a one-cell move this cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        step    = 1'b0;
        if (!one_hot) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end else if (dir_vec != dir_q) begin
            step    = 1'b1;
            state_d = S_DELAY;
            cnt_d   = '0;
        end else begin
            case (state_q)
                S_DELAY: begin
                    if (cnt_q == DLY_LAST) begin
                        step    = 1'b1;
                        state_d = S_REPEAT;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_REPEAT: begin
                    if (cnt_q == RATE_LAST) begin
                        step  = 1'b1;
                        cnt_d = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Snapping off a disabled cell takes priority over any requested step.
    always_comb begin
        pos_x_d = pos_x_q;
        pos_y_d = pos_y_q;
        moved_d = 1'b0;
        if (!no_valid) begin
            if (!cur_en) begin
                pos_x_d = snap_x;
                pos_y_d = snap_y;
                moved_d = 1'b1;
            end else if (step && seek_found) begin
                if (horiz) begin
                    pos_x_d = XW'(seek_idx);
                end else begin
                    pos_y_d = YW'(seek_idx);
                end
                moved_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dir_q   <= '0;
            state_q <= S_IDLE;
            cnt_q   <= '0;
            pos_x_q <= '0;
            pos_y_q <= '0;
            moved_q <= 1'b0;
        end else begin
            dir_q   <= dir_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pos_x_q <= pos_x_d;
            pos_y_q <= pos_y_d;
            moved_q <= moved_d;
        end
    end

endmodule

// File: tb/tb_keypad_cursor.sv
module tb_keypad_cursor;
    import keypad_cursor_pkg::*;

    // Cells (0..3,3) and (2..3,2) disabled: bits 14,15,18,19,20,21 clear.
    localparam logic [23:0] MASK = 24'hC33FFF;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        dir_up = 1'b0, dir_down = 1'b0, dir_left = 1'b0, dir_right = 1'b0;
    logic [23:0] cell_en = MASK;
    logic [2:0]  pos_x;
    logic [1:0]  pos_y;
    logic [4:0]  val;
    logic        moved;
    logic        no_valid;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    keypad_cursor #(
        .COLS      (6),
        .ROWS      (4),
        .REP_DELAY (4),
        .REP_RATE  (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .dir_up    (dir_up),
        .dir_down  (dir_down),
        .dir_left  (dir_left),
        .dir_right (dir_right),
        .cell_en   (cell_en),
        .pos_x     (pos_x),
        .pos_y     (pos_y),
        .val       (val),
        .moved     (moved),
        .no_valid  (no_valid)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_dir(input logic [3:0] v);
        {dir_right, dir_left, dir_down, dir_up} = v;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_pos(input string tag, input int x, input int y, input int mv);
        chk({tag, "_x"}, 32'(pos_x), x);
        chk({tag, "_y"}, 32'(pos_y), y);
        chk({tag, "_val"}, 32'(val), y * 6 + x);
        chk({tag, "_moved"}, 32'(moved), mv);
    endtask

    // One-cycle press followed by one-cycle release.
    task automatic tap(input logic [3:0] v);
        set_dir(v);
        tick(1);
        set_dir(4'b0000);
        tick(1);
    endtask

    int exp_x[10] = '{1, 1, 1, 1, 2, 2, 3, 3, 4, 4};
    int exp_m[10] = '{1, 0, 0, 0, 1, 0, 1, 0, 1, 0};

    initial begin
        // Reset state
        tick(2);
        chk_pos("reset", 0, 0, 0);
        chk("reset_state", 32'(dut.state_q), 32'(S_IDLE));
        chk("reset_no_valid", 32'(no_valid), 0);
        rst = 1'b0;
        tick(1);
        chk_pos("post_reset", 0, 0, 0);

        // Right held 10 cycles: moves at 1, 5, 7, 9
        set_dir(DIR_RIGHT);
        for (int unsigned i = 0; i < 10; i++) begin
            tick(1);
            chk($sformatf("hold%0d_x", i + 1), 32'(pos_x), exp_x[i]);
            chk($sformatf("hold%0d_moved", i + 1), 32'(moved), exp_m[i]);
        end
        set_dir(4'b0000);
        tick(1);
        chk_pos("hold_release", 4, 0, 0);
        chk("hold_release_state", 32'(dut.state_q), 32'(S_IDLE));

        // Left wraps from (0,0) to (5,0)
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        tick(1);
        set_dir(DIR_LEFT);
        tick(1);
        chk_pos("left_wrap", 5, 0, 1);
        set_dir(4'b0000);
        tick(1);
        chk_pos("left_wrap_rel", 5, 0, 0);

        // Right wraps back to 0, then on to (2,0)
        tap(DIR_RIGHT);
        chk_pos("right_wrap", 0, 0, 0);
        tap(DIR_RIGHT);
        tap(DIR_RIGHT);
        chk_pos("to_2_0", 2, 0, 0);

        // Up from (2,0) wraps and skips disabled (2,3),(2,2)
        set_dir(DIR_UP);
        tick(1);
        chk_pos("up_skip", 2, 1, 1);
        set_dir(4'b0000);
        tick(1);

        // To (1,2), then right skips (2,2),(3,2)
        tap(DIR_LEFT);
        chk_pos("to_1_1", 1, 1, 0);
        tap(DIR_DOWN);
        chk_pos("to_1_2", 1, 2, 0);
        set_dir(DIR_RIGHT);
        tick(1);
        chk_pos("right_skip", 4, 2, 1);
        set_dir(4'b0000);
        tick(1);
        chk_pos("right_skip_rel", 4, 2, 0);

        // To (3,1), then up+right together: no move
        tap(DIR_UP);
        chk_pos("to_4_1", 4, 1, 0);
        tap(DIR_LEFT);
        chk_pos("to_3_1", 3, 1, 0);
        set_dir(DIR_UP | DIR_RIGHT);
        tick(1);
        chk_pos("multi_hot", 3, 1, 0);
        chk("multi_hot_state", 32'(dut.state_q), 32'(S_IDLE));
        tick(5);
        chk_pos("multi_hot_held", 3, 1, 0);
        set_dir(4'b0000);
        tick(1);

        // To (5,1), then clear its enable bit: snap to (0,0)
        tap(DIR_RIGHT);
        tap(DIR_RIGHT);
        chk_pos("to_5_1", 5, 1, 0);
        cell_en = MASK & ~(24'd1 << 11);
        tick(1);
        chk_pos("snap", 0, 0, 1);
        tick(1);
        chk_pos("snap_after", 0, 0, 0);

        // All-zero mask: hold, no_valid, presses ignored
        cell_en = MASK;
        tap(DIR_RIGHT);
        chk_pos("to_1_0", 1, 0, 0);
        cell_en = '0;
        tick(1);
        chk("empty_no_valid", 32'(no_valid), 1);
        chk_pos("empty_hold", 1, 0, 0);
        set_dir(DIR_RIGHT);
        tick(1);
        chk_pos("empty_press", 1, 0, 0);
        set_dir(4'b0000);
        tick(1);

        // Disabled (0,0) after reset snaps on the first edge out of reset
        cell_en = MASK & ~24'd1;
        rst = 1'b1;
        tick(1);
        chk_pos("rst_disabled", 0, 0, 0);
        rst = 1'b0;
        tick(1);
        chk_pos("rst_snap", 1, 0, 1);
        chk("rst_snap_no_valid", 32'(no_valid), 0);

        // Reset during REPEAT with right held
        cell_en = MASK;
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        tick(1);
        set_dir(DIR_RIGHT);
        tick(6);
        chk_pos("repeat_pre", 2, 0, 0);
        chk("repeat_state", 32'(dut.state_q), 32'(S_REPEAT));
        rst = 1'b1;
        tick(1);
        chk_pos("repeat_rst", 0, 0, 0);
        chk("repeat_rst_state", 32'(dut.state_q), 32'(S_IDLE));
        rst = 1'b0;
        tick(1);
        chk_pos("repeat_new_press", 1, 0, 1);
        chk("repeat_new_state", 32'(dut.state_q), 32'(S_DELAY));
        set_dir(4'b0000);
        tick(1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
